// File: rtl/wb_arbiter_pkg.sv
// Shared constants and types for the write-back arbiter: register-address width,
// register count, grant-pointer encoding and a one-hot register mask helper.
package wb_arbiter_pkg;

  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;

  typedef enum logic {
    SRC_EXU = 1'b0,
    SRC_LSU = 1'b1
  } src_t;

  // x0 never appears in the scoreboard, so its mask is always empty.
  function automatic logic [NUM_REGS-1:0] reg_mask(input logic [REG_AW-1:0] r);
    logic [NUM_REGS-1:0] m;
    m = '0;
    if (r != '0) m[r] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Per-producer result FIFO holding {rd, data}; ready is derived only from the
// registered occupancy, so there is no valid-to-ready combinational path.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [REG_AW-1:0] push_rd,
  input  logic [XLEN-1:0]   push_data,
  input  logic              pop,
  output logic              head_valid,
  output logic [REG_AW-1:0] head_rd,
  output logic [XLEN-1:0]   head_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("wb_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [REG_AW-1:0] rd_mem   [DEPTH];
  logic [XLEN-1:0]   data_mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              do_push;
  logic              do_pop;

  assign push_ready = (count != CW'(DEPTH));
  assign head_valid = (count != '0);
  assign head_rd    = rd_mem[rd_ptr];
  assign head_data  = data_mem[rd_ptr];
  assign do_push    = push_valid && push_ready;
  assign do_pop     = pop && head_valid;

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      rd_mem[wr_ptr]   <= push_rd;
      data_mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  assert property (@(posedge clk) disable iff (rst) pop |-> head_valid);

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: round-robin between EXU and LSU result FIFOs into one
// registered register-file write per cycle, plus the busy-register scoreboard.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                exu_valid,
  output logic                exu_ready,
  input  logic [REG_AW-1:0]   exu_rd,
  input  logic [XLEN-1:0]     exu_data,
  input  logic                lsu_valid,
  output logic                lsu_ready,
  input  logic [REG_AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0]     lsu_data,
  input  logic                issue_valid,
  input  logic [REG_AW-1:0]   issue_rd,
  output logic [REG_AW-1:0]   waddr,
  output logic [XLEN-1:0]     wdata,
  output logic                we,
  output logic [NUM_REGS-1:0] busy
);

  logic                exu_head_valid;
  logic                lsu_head_valid;
  logic [REG_AW-1:0]   exu_head_rd;
  logic [REG_AW-1:0]   lsu_head_rd;
  logic [XLEN-1:0]     exu_head_data;
  logic [XLEN-1:0]     lsu_head_data;
  logic                exu_pop;
  logic                lsu_pop;
  src_t                last_grant;
  src_t                grant_src;
  logic                grant;
  logic [REG_AW-1:0]   grant_rd;
  logic [XLEN-1:0]     grant_data;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  wb_fifo #(.XLEN(XLEN), .DEPTH(DEPTH)) u_exu_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (exu_valid),
    .push_ready (exu_ready),
    .push_rd    (exu_rd),
    .push_data  (exu_data),
    .pop        (exu_pop),
    .head_valid (exu_head_valid),
    .head_rd    (exu_head_rd),
    .head_data  (exu_head_data)
  );

  wb_fifo #(.XLEN(XLEN), .DEPTH(DEPTH)) u_lsu_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (lsu_valid),
    .push_ready (lsu_ready),
    .push_rd    (lsu_rd),
    .push_data  (lsu_data),
    .pop        (lsu_pop),
    .head_valid (lsu_head_valid),
    .head_rd    (lsu_head_rd),
    .head_data  (lsu_head_data)
  );

  // On a tie the source that did not win last time takes the grant.
  always_comb begin
    grant     = exu_head_valid || lsu_head_valid;
    grant_src = SRC_EXU;
    if (exu_head_valid && lsu_head_valid)
      grant_src = (last_grant == SRC_EXU) ? SRC_LSU : SRC_EXU;
    else if (lsu_head_valid)
      grant_src = SRC_LSU;
  end

  assign grant_rd   = (grant_src == SRC_LSU) ? lsu_head_rd   : exu_head_rd;
  assign grant_data = (grant_src == SRC_LSU) ? lsu_head_data : exu_head_data;
  assign exu_pop    = grant && (grant_src == SRC_EXU);
  assign lsu_pop    = grant && (grant_src == SRC_LSU);

  assign set_mask = issue_valid ? reg_mask(issue_rd) : '0;
  assign clr_mask = grant ? reg_mask(grant_rd) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we         <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
      last_grant <= SRC_EXU;
    end else begin
      we <= 1'b0;
      if (grant) begin
        last_grant <= grant_src;
        // An x0 result still consumes its slot but never reaches the register file.
        if (grant_rd != '0) begin
          we    <= 1'b1;
          waddr <= grant_rd;
          wdata <= grant_data;
        end
      end
    end
  end

  // Set is applied after clear so a same-edge issue keeps the bit pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= (busy & ~clr_mask) | set_mask;
  end

  assert property (@(posedge clk) disable iff (rst)
    (issue_valid && issue_rd != '0) |-> (!busy[issue_rd] || clr_mask[issue_rd]));

endmodule
